// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator. Holds off until the PLL lock flag has been
// stable for LOCK_WAIT cycles, then free-runs h/v counters and decodes sync/DE.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int LW       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, de_q, de_d;
    logic          frame_start_q, frame_start_d, running_q, running_d;
    logic [9:0]    x_q, x_d, y_q, y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            lock_cnt_q    <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    // Lock loss is checked before the counter advance so it always wins.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        h_d        = h_q;
        v_d        = v_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!pll_locked) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = RUN;
                    lock_cnt_d = '0;
                    h_d        = '0;
                    v_d        = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            RUN: begin
                if (!pll_locked) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    h_d        = '0;
                    v_d        = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                h_d        = '0;
                v_d        = '0;
            end
        endcase
    end

    // Decoding the next-state position lets registered outputs line up with the counters.
    always_comb begin
        hsync_n_d     = 1'b1;
        vsync_n_d     = 1'b1;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (state_d == RUN) begin
            de_d          = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
            hsync_n_d     = !((int'(h_d) >= HS_START) && (int'(h_d) < HS_END));
            vsync_n_d     = !((int'(v_d) >= VS_START) && (int'(v_d) < VS_END));
            x_d           = h_d;
            y_d           = v_d;
            frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
            running_d     = 1'b1;
        end
    end

    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines with a shortened vertical raster so
// whole frames fit the run, checked cycle by cycle against a raster-time model.
module tb_vga_timing_gen;

    localparam int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACT = 20, V_FP = 3, V_SYNC = 2, V_BP = 4;
    localparam int LOCK_WAIT = 16;
    localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       hsync_n, vsync_n, de, frame_start, running;
    logic [9:0] x, y;
    logic [24:0] outs;
    logic [24:0] idle_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: raster time t counts RUN cycles since the last start; position is t mod line/frame.
    logic m_run = 1'b0;
    int   m_t = 0;
    int   m_streak = 0;

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .LOCK_WAIT(LOCK_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    assign outs   = {running, frame_start, de, hsync_n, vsync_n, x, y};
    assign idle_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0; m_t <= 0; m_streak <= 0;
        end else if (m_run) begin
            if (!pll_locked) begin
                m_run <= 1'b0; m_t <= 0; m_streak <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (pll_locked) begin
            if (m_streak + 1 == LOCK_WAIT) begin
                m_run <= 1'b1; m_t <= 0; m_streak <= 0;
            end else begin
                m_streak <= m_streak + 1;
            end
        end else begin
            m_streak <= 0;
        end
    end

    function automatic logic [24:0] exp_vec();
        int h, v;
        logic e_de, e_hs, e_vs, e_fs;
        if (!m_run) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
        h    = m_t % HT;
        v    = (m_t / HT) % VT;
        e_de = (h < H_ACT) && (v < V_ACT);
        e_hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
        e_vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
        e_fs = (h == 0) && (v == 0);
        return {1'b1, e_fs, e_de, e_hs, e_vs, 10'(h), 10'(v)};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'(($urandom_range(0, 1)));
            cyc();
            n_tests++;
            if (outs !== idle_v) begin
                n_fail++; $display("FAIL reset_idle got %h want %h", outs, idle_v);
            end
        end
    endtask

    task automatic test_startup();
        int first = -1;
        rst = 1'b0; pll_locked = 1'b1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            cyc();
            n_tests++;
            if (outs !== exp_vec()) begin
                n_fail++; $display("FAIL startup_model got %h want %h", outs, exp_vec());
            end
            if (running) first = i;
        end
        n_tests++;
        if (first != LOCK_WAIT) begin
            n_fail++; $display("FAIL startup_latency got %0d want %0d", first, LOCK_WAIT);
        end
        n_tests++;
        if ({x, y, de, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL startup_pos got x=%0d y=%0d de=%b fs=%b want 0 0 1 1",
                               x, y, de, frame_start);
        end
    endtask

    task automatic test_line();
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, xbad = 0;
        for (int i = 0; i < HT; i++) begin
            if (int'(x) != i || y != 10'd0) xbad++;
            if (de) de_cnt++;
            if (!hsync_n) begin
                hs_cnt++; hs_last = i;
                if (hs_first < 0) hs_first = i;
            end
            cyc();
            n_tests++;
            if (outs !== exp_vec()) begin
                n_fail++; $display("FAIL line_model got %h want %h", outs, exp_vec());
            end
        end
        n_tests++;
        if (xbad != 0) begin n_fail++; $display("FAIL line_x_seq got %0d bad want 0", xbad); end
        n_tests++;
        if (de_cnt != H_ACT) begin n_fail++; $display("FAIL line_de_cnt got %0d want %0d", de_cnt, H_ACT); end
        n_tests++;
        if (hs_cnt != H_SYNC || hs_first != H_ACT + H_FP || hs_last != H_ACT + H_FP + H_SYNC - 1) begin
            n_fail++; $display("FAIL line_hsync got cnt=%0d first=%0d last=%0d want 96 656 751",
                               hs_cnt, hs_first, hs_last);
        end
        n_tests++;
        if (x !== 10'd0 || y !== 10'd1) begin
            n_fail++; $display("FAIL line_wrap got x=%0d y=%0d want 0 1", x, y);
        end
    endtask

    task automatic test_frame();
        int elapsed = HT, vs_cnt = 0, px = 0, py = 0;
        bit seen = 0;
        for (int i = 0; i < HT * VT + 10 && !seen; i++) begin
            if (!vsync_n) vs_cnt++;
            px = int'(x); py = int'(y);
            cyc();
            elapsed++;
            n_tests++;
            if (outs !== exp_vec()) begin
                n_fail++; $display("FAIL frame_model got %h want %h", outs, exp_vec());
            end
            if (frame_start) seen = 1;
        end
        n_tests++;
        if (!seen || elapsed != HT * VT) begin
            n_fail++; $display("FAIL frame_period got %0d seen=%0d want %0d", elapsed, seen, HT * VT);
        end
        n_tests++;
        if (vs_cnt != V_SYNC * HT) begin
            n_fail++; $display("FAIL frame_vsync got %0d want %0d", vs_cnt, V_SYNC * HT);
        end
        n_tests++;
        if (px != HT - 1 || py != VT - 1 || x !== 10'd0 || y !== 10'd0) begin
            n_fail++; $display("FAIL frame_wrap got prev %0d,%0d now %0d,%0d want %0d,%0d now 0,0",
                               px, py, x, y, HT - 1, VT - 1);
        end
    endtask

    task automatic test_glitch();
        int lat = -1;
        for (int i = 0; i < 60; i++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            cyc();
            n_tests++;
            if (outs !== exp_vec()) begin
                n_fail++; $display("FAIL glitch_rand got %h want %h", outs, exp_vec());
            end
        end
        pll_locked = 1'b0; cyc();
        pll_locked = 1'b1;
        repeat (10) cyc();
        pll_locked = 1'b0; cyc();
        n_tests++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL glitch_early got running=%b want 0", running); end
        pll_locked = 1'b1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            cyc();
            n_tests++;
            if (outs !== exp_vec()) begin
                n_fail++; $display("FAIL glitch_model got %h want %h", outs, exp_vec());
            end
            if (running) lat = i;
        end
        n_tests++;
        if (lat != LOCK_WAIT) begin n_fail++; $display("FAIL glitch_restart got %0d want %0d", lat, LOCK_WAIT); end
    endtask

    task automatic test_lock_loss();
        int tx = int'($urandom_range(0, HT - 1));
        int ty = int'($urandom_range(1, 3));
        int lat = -1;
        bit hit = 0;
        for (int i = 0; i < HT * VT && !hit; i++) begin
            if (int'(x) == tx && int'(y) == ty && running) hit = 1;
            else begin
                cyc();
                n_tests++;
                if (outs !== exp_vec()) begin
                    n_fail++; $display("FAIL loss_model got %h want %h", outs, exp_vec());
                end
            end
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL loss_reach got none want x=%0d y=%0d", tx, ty); end
        pll_locked = 1'b0; cyc();
        n_tests++;
        if (outs !== idle_v) begin n_fail++; $display("FAIL loss_idle got %h want %h", outs, idle_v); end
        pll_locked = 1'b1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            cyc();
            if (running) lat = i;
        end
        n_tests++;
        if (lat != LOCK_WAIT || {x, y, frame_start} !== {10'd0, 10'd0, 1'b1}) begin
            n_fail++; $display("FAIL loss_restart got lat=%0d x=%0d y=%0d fs=%b want %0d 0 0 1",
                               lat, x, y, frame_start, LOCK_WAIT);
        end
    endtask

    task automatic test_rst_midframe();
        int ty = V_ACT + V_FP + 1;
        bit hit = 0;
        for (int i = 0; i < HT * VT + 10 && !hit; i++) begin
            if (int'(x) == 700 && int'(y) == ty) hit = 1;
            else begin
                cyc();
                n_tests++;
                if (outs !== exp_vec()) begin
                    n_fail++; $display("FAIL rst_model got %h want %h", outs, exp_vec());
                end
            end
        end
        n_tests++;
        if (!hit || hsync_n !== 1'b0 || vsync_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre got hit=%0d hs=%b vs=%b want 1 0 0", hit, hsync_n, vsync_n);
        end
        rst = 1'b1; cyc();
        n_tests++;
        if (outs !== idle_v) begin n_fail++; $display("FAIL rst_idle got %h want %h", outs, idle_v); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_frame();
        test_glitch();
        test_lock_loss();
        test_rst_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
